// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with parity and stop checks, 2-flop rx synchronizer
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       ret,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
    state_t state, state_n;
    logic rx_m, rx_s, armed, fin, stop_b, par_b, half, full;
    logic [15:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    assign half = cnt == HALF;
    assign full = cnt == FULL;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (!rx_s && armed) ? START : IDLE;
            START:   state_n = half ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_n = (full && idx == 3'd7) ? PARITY : DATA;
            PARITY:  state_n = full ? STOP : PARITY;
            STOP:    state_n = full ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (ret) begin
            state      <= IDLE;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            armed      <= 1'b1;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_b      <= 1'b0;
            stop_b     <= 1'b0;
            fin        <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            state <= state_n;
            cnt   <= (state == IDLE || full || (state == START && half)) ? '0 : cnt + 16'd1;
            if (state == DATA && full) begin
                shreg[idx] <= rx_s;
                idx        <= idx + 3'd1;
            end
            if (state == PARITY && full) par_b <= rx_s;
            if (state == STOP && full) stop_b <= rx_s;
            fin   <= state == STOP && full;
            armed <= (state == STOP && full) ? rx_s : (armed | rx_s);
            valid <= fin;
            if (fin) begin
                data       <= shreg;
                parity_err <= (^shreg ^ par_b) != PARITY_ODD;
                frame_err  <= !stop_b;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a byte-level UART reference model
module tb_uart_rx;
    localparam int CPB = 16;
    localparam bit ODD = 1'b0;
    logic clk = 1'b0, ret = 1'b1, rx = 1'b1;
    logic [7:0] data;
    logic valid, parity_err, frame_err, busy;
    typedef struct {logic [7:0] d; logic pe; logic fe; int t;} ev_t;
    ev_t got[$];
    int starts[$];
    int cyc = 0, checks = 0, passes = 0, fails = 0, last_t = 0, first_t = 0, n = 0;
    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(ODD)) dut (
        .clk(clk), .ret(ret), .rx(rx), .data(data), .valid(valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (valid) got.push_back('{data, parity_err, frame_err, cyc});
    function automatic logic model_pe(input logic [7:0] d, input logic p);
        return ((($countones(d) + int'(p)) % 2) != int'(ODD));
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send_bit(input logic b, input logic pulse);
        rx = b;
        for (int k = 0; k < CPB; k++) begin
            ret = pulse && k == 4;
            @(negedge clk);
        end
        ret = 1'b0;
    endtask
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic pulse_d4);
        starts.push_back(cyc);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], pulse_d4 && i == 4);
        send_bit(p, 1'b0);
        send_bit(s, 1'b0);
    endtask
    task automatic take(input string tag, input logic [7:0] d, input logic p, input logic s);
        ev_t r;
        int t;
        check({tag, " count"}, got.size(), 1);
        if (got.size() > 0 && starts.size() > 0) begin
            r = got.pop_front();
            t = starts.pop_front();
            last_t = r.t;
            check({tag, " data"}, r.d, d);
            check({tag, " parity_err"}, r.pe, model_pe(d, p));
            check({tag, " frame_err"}, r.fe, !s);
            check({tag, " latency"}, (r.t - t >= 171 && r.t - t <= 172), 1);
        end
        got.delete();
        starts.delete();
    endtask
    initial begin
        logic [7:0] d;
        logic p;
        int gap;
        repeat (3) @(negedge clk);
        check("reset data", data, 8'h00);
        check("reset valid", valid, 0);
        check("reset parity_err", parity_err, 0);
        check("reset frame_err", frame_err, 0);
        check("reset busy", busy, 0);
        ret = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h75, 1'b1, 1'b1, 1'b0);
        take("f75", 8'h75, 1'b1, 1'b1);
        check("f75 busy idle", busy, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        take("fA5", 8'hA5, 1'b1, 1'b1);
        check("fA5 held parity_err", parity_err, 1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        take("break", 8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        check("break held frame_err", frame_err, 1);
        check("break no extra valid", got.size(), 0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("break after high", got.size(), 0);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        n = 0;
        while (busy && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("glitch busy clears", busy, 0);
        repeat (12 * CPB) @(negedge clk);
        check("glitch no valid", got.size(), 0);
        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        repeat (CPB) @(negedge clk);
        check("b2b count", got.size(), 2);
        if (got.size() == 2) begin
            first_t = got[0].t;
            check("b2b first data", got[0].d, 8'h00);
            check("b2b first flags", {got[0].pe, got[0].fe}, 2'b00);
            check("b2b second data", got[1].d, 8'hFF);
            check("b2b second flags", {got[1].pe, got[1].fe}, 2'b00);
            check("b2b spacing", got[1].t - first_t, 176);
        end
        got.delete();
        starts.delete();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("abort no valid", got.size(), 0);
        check("abort data cleared", data, 8'h00);
        got.delete();
        starts.delete();
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        take("f81", 8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            send_frame(d, p, 1'b1, 1'b0);
            take("rand", d, p, 1'b1);
            rx = 1'b1;
            repeat (gap * CPB) @(negedge clk);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
